// File: rtl/uart_tx_state.sv
// 8N1 UART transmitter for the tester state: frames {HDR, data} and shifts it out LSB first.
// Line low one cycle after accept, done pulse 10*CLKS_PER_BIT+1 cycles after accept; requests ignored until HOLD sees send_en low.
module uart_tx_state #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [1:0] HDR          = 2'b00
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_send_en,
  input  logic [5:0] in_data,
  output logic       out_tx,
  output logic       out_busy,
  output logic       out_done
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (in_send_en) begin
          shift_d = {HDR, in_data};
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_end) state_d = S_HOLD;
      end
      S_HOLD: begin
        // Re-arm guard: a request still high after done must drop before another frame.
        baud_d = '0;
        if (!in_send_en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    // Outputs are computed from the next state so they come straight from flops.
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    done_d = (state_q == S_STOP) && (state_d == S_HOLD);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_tx   = tx_q;
  assign out_busy = busy_q;
  assign out_done = done_q;

endmodule

// File: tb/tb_uart_tx_state.sv
// Directed stimulus for two transmitters (HDR=00 and HDR=11); a per-instance monitor
// decodes every frame off the line and checks it against the expected-byte queue.
module tb_uart_tx_state;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send0 = 1'b0, send1 = 1'b0;
  logic [5:0] data0 = 6'd0, data1 = 6'd0;
  logic [1:0] tx, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int last_done [2] = '{-1, -1};
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  uart_tx_state #(.CLKS_PER_BIT(CPB), .HDR(2'b00)) dut (
    .in_clk(clk), .in_rst(rst), .in_send_en(send0), .in_data(data0),
    .out_tx(tx[0]), .out_busy(busy[0]), .out_done(done[0])
  );

  uart_tx_state #(.CLKS_PER_BIT(CPB), .HDR(2'b11)) dut_h (
    .in_clk(clk), .in_rst(rst), .in_send_en(send1), .in_data(data1),
    .out_tx(tx[1]), .out_busy(busy[1]), .out_done(done[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame monitor: one instance per DUT, sampling on the falling edge.
  task automatic mon(input int id);
    logic       prev;
    logic       have, shape_ok, aborted, eb;
    logic [7:0] expb, rx;
    int         b;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        last_done[id] = -1;
        continue;
      end
      if (busy[id] && !prev) begin
        have = 1'b0;
        expb = 8'h00;
        if (id == 0 && exp0.size() > 0) begin have = 1'b1; expb = exp0.pop_front(); end
        if (id == 1 && exp1.size() > 0) begin have = 1'b1; expb = exp1.pop_front(); end
        if (last_done[id] >= 0)
          check(cyc - last_done[id] >= 2, "frame_gap", cyc - last_done[id], 2);
        shape_ok = 1'b1;
        aborted  = 1'b0;
        rx       = 8'h00;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
          b  = i / CPB;
          eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : expb[b-1];
          if (b >= 1 && b <= 8 && (i % CPB) == CPB / 2) rx[b-1] = tx[id];
          if (tx[id] !== eb || busy[id] !== 1'b1 || done[id] !== 1'b0) shape_ok = 1'b0;
        end
        if (!aborted) begin
          @(negedge clk);
          check(have, "frame_expected", 0, 1);
          if (have) begin
            check(rx == expb, "frame_byte", rx, expb);
            check(shape_ok, "frame_shape", 0, 1);
          end
          check(done[id] === 1'b1 && busy[id] === 1'b0 && tx[id] === 1'b1, "done_pulse",
                {done[id], busy[id], tx[id]}, 3'b101);
          frames[id]++;
          if (done[id] === 1'b1) done_cnt[id]++;
          last_done[id] = cyc;
          @(negedge clk);
          check(done[id] === 1'b0, "done_width", done[id], 0);
          prev = busy[id];
        end else begin
          prev = 1'b0;
          last_done[id] = -1;
        end
        continue;
      end
      prev = busy[id];
    end
  endtask

  initial fork
    mon(0);
    mon(1);
  join_none

  // Present a one-cycle request; returns in cycle k+1 after the accept edge k.
  task automatic send_pulse(input int id, input logic [5:0] d);
    if (id == 0) begin data0 = d; send0 = 1'b1; end
    else begin data1 = d; send1 = 1'b1; end
    tick();
    send0 = 1'b0;
    send1 = 1'b0;
    check(busy[id] === 1'b1 && tx[id] === 1'b0, "accept_timing", {busy[id], tx[id]}, 2'b10);
  endtask

  initial begin
    int f0, d0, t;
    bit ok;
    logic [5:0] hs [3];
    hs[0] = 6'h01; hs[1] = 6'h20; hs[2] = 6'h15;

    // Reset state
    repeat (3) tick();
    check(tx === 2'b11 && busy === 2'b00 && done === 2'b00, "reset_state", {tx, busy, done}, 6'b110000);
    rst = 1'b0;
    repeat (2) tick();

    // Reset mid-frame, during data bit 3 of byte 0x37 (bit 3 = 0)
    send_pulse(0, 6'h37);
    repeat (17) tick();
    check(tx[0] === 1'b0 && busy[0] === 1'b1, "pre_reset_bit3", {tx[0], busy[0]}, 2'b01);
    rst = 1'b1;
    #1;
    check(tx[0] === 1'b1 && busy[0] === 1'b0 && done[0] === 1'b0, "reset_midframe",
          {tx[0], busy[0], done[0]}, 3'b100);
    repeat (2) tick();
    rst = 1'b0;
    f0 = frames[0];
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) ok = 1'b0;
    end
    check(ok && frames[0] == f0, "idle_silent", frames[0] - f0, 0);

    // Single frame, 0x2D: busy k+1..k+40, done only at k+41
    exp0.push_back(8'h2D);
    send_pulse(0, 6'b101101);
    repeat (39) tick();
    check(busy[0] === 1'b1 && tx[0] === 1'b1 && done[0] === 1'b0, "stop_last_cycle",
          {busy[0], tx[0], done[0]}, 3'b110);
    tick();
    check(done[0] === 1'b1 && busy[0] === 1'b0, "done_at_k41", {done[0], busy[0]}, 2'b10);
    repeat (4) tick();

    // Held request: one frame only, then re-arm
    f0 = frames[0];
    exp0.push_back(8'h2A);
    data0 = 6'h2A;
    send0 = 1'b1;
    repeat (41) tick();
    check(done[0] === 1'b1, "held_done", done[0], 1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) ok = 1'b0;
    end
    check(ok && frames[0] == f0 + 1, "held_no_refire", frames[0] - f0, 1);
    send0 = 1'b0;
    tick();
    check(busy[0] === 1'b0 && tx[0] === 1'b1, "rearm_idle", {busy[0], tx[0]}, 2'b01);
    exp0.push_back(8'h2A);
    send0 = 1'b1;
    tick();
    send0 = 1'b0;
    check(busy[0] === 1'b1 && tx[0] === 1'b0, "rearm_start", {busy[0], tx[0]}, 2'b10);
    repeat (44) tick();

    // Data change mid-frame is ignored
    exp0.push_back(8'h3F);
    send_pulse(0, 6'h3F);
    repeat (4) tick();
    data0 = 6'h00;
    repeat (44) tick();

    // FSM-style handshake loop
    f0 = frames[0];
    d0 = done_cnt[0];
    for (int n = 0; n < 3; n++) begin
      t = 0;
      while (busy[0] !== 1'b0 && t < 100) begin tick(); t++; end
      check(t < 100, "hs_wait_idle", t, 0);
      data0 = hs[n];
      exp0.push_back({2'b00, hs[n]});
      send0 = 1'b1;
      t = 0;
      while (done[0] !== 1'b1 && t < 200) begin tick(); t++; end
      check(t < 200, "hs_wait_done", t, 0);
      tick();
      send0 = 1'b0;
      tick();
    end
    repeat (3) tick();
    check(done_cnt[0] - d0 == 3 && frames[0] - f0 == 3, "hs_three_frames", done_cnt[0] - d0, 3);

    // Header parameter: HDR=11, data 0 -> byte 0xC0
    exp1.push_back(8'hC0);
    send_pulse(1, 6'h00);
    repeat (44) tick();

    t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && t < 100) begin tick(); t++; end
    check(exp0.size() == 0 && exp1.size() == 0, "queues_drained", exp0.size() + exp1.size(), 0);
    check(frames[0] == 7 && frames[1] == 1, "frame_totals", frames[0] * 16 + frames[1], 7 * 16 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_state.md
Name: uart_tx_state

Overview:
- UART transmitter stage directly downstream of the tester control FSM.
- On a send request, frames the 6-bit tester state with a 2-bit reply header into one 8N1 byte and shifts it out on the serial line.
- Reports busy and done back to the FSM. The FSM uses these for its wait and send states.

Parameters:
- CLKS_PER_BIT, 434: in_clk cycles per UART bit (50 MHz / 115200). Must be >= 2.
- HDR, 2'b00: value placed in byte bits [7:6] of every transmitted frame.

Ports:
- in_clk  input  1  system clock; all logic on rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_send_en  input  1  send request (level). Sampled only in IDLE.
- in_data  input  6  tester state to transmit. Latched at accept.
- out_tx  output  1  UART serial line. Idle high.
- out_busy  output  1  frame in progress (registered).
- out_done  output  1  one-cycle pulse when the stop bit completes (registered).

Behaviour:
- Reset (async, in_rst=1):
  - state=IDLE, out_tx=1, out_busy=0, out_done=0.
  - Bit counter, baud counter and shift register cleared.
  - Effective immediately, including mid-frame: the partial frame is abandoned and the line returns high.
- Frame format:
  - byte = {HDR, data[5:0]}.
  - Sent as start bit (0), byte bits 0..7 (LSB first), stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - Reloaded to 0 on every state entry.
- Bit index: 3 bits, 0..7, used in DATA only. Wrap from 7 ends DATA.
- States:
  - IDLE: out_tx=1, busy=0. If in_send_en=1 at an edge, latch {HDR,in_data} into the shift register and go to START.
  - START: out_tx=0, busy=1. After CLKS_PER_BIT cycles go to DATA with bit index=0.
  - DATA: out_tx=shift[bit index], busy=1. Each bit lasts CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: out_tx=1, busy=1. After CLKS_PER_BIT cycles go to HOLD and assert out_done for the single cycle of HOLD entry.
  - HOLD: out_tx=1, busy=0.
    - Re-arm guard: stay in HOLD while in_send_en=1; go to IDLE on the first cycle in_send_en=0.
    - A request held high across done therefore never causes a second frame.
- Timing, with accept at edge k (IDLE, in_send_en=1):
  - out_busy=1 and out_tx=0 from cycle k+1.
  - Stop bit ends at cycle k+10*CLKS_PER_BIT.
  - out_done=1 and out_busy=0 in cycle k+10*CLKS_PER_BIT+1.
  - out_done is exactly one cycle wide.
- All outputs are register-driven with no combinational path from inputs, so out_tx is glitch-free.
- in_data and in_send_en changes while busy or in HOLD are ignored. Data is taken only at accept.
- out_busy and out_done are never high in the same cycle.
- Back-to-back frames: minimum gap is one HOLD cycle plus one IDLE cycle of high line between the stop bit and the next start bit.

Test Plan:
- Use CLKS_PER_BIT=4 for the bench.
- Reset mid-frame: raise in_rst during DATA bit 3 -> same cycle out_tx=1, out_busy=0, out_done=0. After release, the block sits in IDLE and stays silent with in_send_en=0.
- Single frame: HDR=00, in_data=6'b101101, pulse in_send_en for 1 cycle at edge k.
  - Line sequence from k+1, each bit 4 cycles: 0 | 1,0,1,1,0,1,0,0 | 1.
  - out_busy=1 for cycles k+1..k+40; out_done=1 only at k+41.
- Held request: keep in_send_en=1 through done and for 20 more cycles -> exactly one frame, line stays high, state HOLD. Drop in_send_en, raise it again -> a second frame starts 2 cycles later.
- Data change during frame: in_data=6'h3F at accept, switched to 6'h00 after 5 cycles -> the transmitted byte is still 8'h3F.
- FSM handshake loop: drive in_send_en high while out_busy=0, low one cycle after out_done (mimicking the FSM wait, send and idle states), three times with data 0x01, 0x20, 0x15. Expect:
  - three correct frames;
  - three done pulses;
  - gaps between frames of at least 2 high cycles.
- Header parameter: HDR=2'b11, in_data=6'h00 -> data bits on the line 0,0,0,0,0,0,1,1.
